// File: rtl/mmio_rd_scheduler.sv
// MMIO read scheduler: queues read requests, issues them under an outstanding-read
// allowance, tracks completions with a per-read timeout, and supports queue flush.
module mmio_rd_scheduler #(
  parameter int DEPTH          = 4,
  parameter int READ_ALLOWANCE = 1,
  parameter int TAG_WIDTH      = 10,
  parameter int LADDR_WIDTH    = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [TAG_WIDTH-1:0]   i_req_tag,
  input  logic [1:0]             i_req_length,
  input  logic [15:0]            i_req_id,
  input  logic [LADDR_WIDTH-1:0] i_req_laddr,
  input  logic [2:0]             i_req_attr,
  input  logic [2:0]             i_req_tc,
  output logic                   o_tlp_rd,
  output logic [TAG_WIDTH-1:0]   o_tlp_rd_tag,
  output logic [1:0]             o_tlp_rd_length,
  output logic [15:0]            o_tlp_rd_req_id,
  output logic [LADDR_WIDTH-1:0] o_tlp_rd_lower_addr,
  output logic [2:0]             o_tlp_rd_attr,
  output logic [2:0]             o_tlp_rd_tc,
  input  logic                   i_cpl_done,
  input  logic                   i_flush,
  output logic                   o_timeout,
  output logic [3:0]             o_outstanding,
  output logic [4:0]             o_fifo_count,
  output logic                   o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [1:0]             len;
    logic [15:0]            id;
    logic [LADDR_WIDTH-1:0] laddr;
    logic [2:0]             attr;
    logic [2:0]             tc;
  } req_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  req_t          mem_q [DEPTH];
  req_t          req_in;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [3:0]    out_q, out_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_e        state_q, state_d;
  logic          rd_q, rd_d;
  logic          to_q, to_d;
  req_t          meta_q, meta_d;

  logic push, issue, discard, pop, fire, dec;

  assign req_in = '{tag: i_req_tag, len: i_req_length, id: i_req_id,
                    laddr: i_req_laddr, attr: i_req_attr, tc: i_req_tc};

  // Ready is masked by rst so nothing can be accepted during reset.
  assign o_req_ready = !rst && (state_q == RUN) && (cnt_q < (AW+1)'(DEPTH));

  always_comb begin
    push    = i_req_valid && o_req_ready;
    issue   = (state_q == RUN) && (cnt_q != '0) && (out_q < 4'(READ_ALLOWANCE));
    discard = (state_q == FLUSH) && (cnt_q != '0);
    pop     = issue || discard;

    // Timer measures idle time since the last issue or completion.
    fire  = 1'b0;
    tmo_d = tmo_q + TW'(1);
    if (issue || i_cpl_done || out_q == '0) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
      tmo_d = '0;
      fire  = 1'b1;
    end

    dec    = (i_cpl_done && out_q != '0) || fire;
    out_d  = out_q + {3'b0, issue} - {3'b0, dec};
    cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

    rd_d   = issue;
    to_d   = fire;
    meta_d = issue ? mem_q[rptr_q] : meta_q;

    state_d = state_q;
    case (state_q)
      RUN:   if (i_flush) state_d = FLUSH;
      FLUSH: if (cnt_q == '0 && out_q == '0 && !i_flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      state_q <= RUN;
      rd_q    <= 1'b0;
      to_q    <= 1'b0;
      meta_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
      meta_q  <= meta_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= req_in;
  end

  assign o_tlp_rd            = rd_q;
  assign o_tlp_rd_tag        = meta_q.tag;
  assign o_tlp_rd_length     = meta_q.len;
  assign o_tlp_rd_req_id     = meta_q.id;
  assign o_tlp_rd_lower_addr = meta_q.laddr;
  assign o_tlp_rd_attr       = meta_q.attr;
  assign o_tlp_rd_tc         = meta_q.tc;
  assign o_timeout           = to_q;
  assign o_outstanding       = out_q;
  assign o_fifo_count        = 5'(cnt_q);
  assign o_state             = state_q;

endmodule

// File: tb/tb_mmio_rd_scheduler.sv
// Bench for mmio_rd_scheduler: two instances (allowance 1 and 2) share stimulus and are
// checked every cycle against a queue-based reference model plus directed scenarios.
module tb_mmio_rd_scheduler;

  typedef struct packed {
    logic [9:0]  tag;
    logic [1:0]  len;
    logic [15:0] id;
    logic [6:0]  laddr;
    logic [2:0]  attr;
    logic [2:0]  tc;
  } meta_t;

  logic  clk = 1'b0, rst = 1'b1, valid = 1'b0, cpl = 1'b0, flush = 1'b0;
  meta_t req = '0;

  logic        ready_o [2], rd_o [2], tmo_o [2], st_o [2];
  logic [3:0]  out_o [2];
  logic [4:0]  cnt_o [2];
  logic [9:0]  tag_o [2];
  logic [1:0]  len_o [2];
  logic [15:0] id_o [2];
  logic [6:0]  la_o [2];
  logic [2:0]  at_o [2], tc_o [2];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mmio_rd_scheduler #(
      .DEPTH(4), .READ_ALLOWANCE(g+1), .TAG_WIDTH(10), .LADDR_WIDTH(7), .TIMEOUT_CYCLES(16)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_req_valid(valid), .o_req_ready(ready_o[g]),
      .i_req_tag(req.tag), .i_req_length(req.len), .i_req_id(req.id),
      .i_req_laddr(req.laddr), .i_req_attr(req.attr), .i_req_tc(req.tc),
      .o_tlp_rd(rd_o[g]), .o_tlp_rd_tag(tag_o[g]), .o_tlp_rd_length(len_o[g]),
      .o_tlp_rd_req_id(id_o[g]), .o_tlp_rd_lower_addr(la_o[g]),
      .o_tlp_rd_attr(at_o[g]), .o_tlp_rd_tc(tc_o[g]),
      .i_cpl_done(cpl), .i_flush(flush), .o_timeout(tmo_o[g]),
      .o_outstanding(out_o[g]), .o_fifo_count(cnt_o[g]), .o_state(st_o[g])
    );
  end

  // Reference model: queue of pending requests, in-flight count, idle timer, mode.
  meta_t mq [2][$];
  int    mst [2], mout [2], midle [2];
  bit    mrd [2], mto [2];
  meta_t mmeta [2];

  task automatic chk(input string name, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", name, k, obs, exp);
    end
  endtask

  task automatic mstep(input int k);
    int  c, o, ra;
    bit  iss, fire, dec;
    c  = mq[k].size();
    o  = mout[k];
    ra = k + 1;
    if (rst) begin
      mq[k].delete();
      mst[k] = 0; mout[k] = 0; midle[k] = 0;
      mrd[k] = 0; mto[k] = 0; mmeta[k] = '0;
      return;
    end
    iss  = (mst[k] == 0) && (c > 0) && (o < ra);
    fire = 0;
    if (iss || cpl || o == 0) midle[k] = 0;
    else if (midle[k] == 15) begin fire = 1; midle[k] = 0; end
    else midle[k]++;
    dec     = (cpl && o > 0) || fire;
    mout[k] = o + int'(iss) - int'(dec);
    mrd[k]  = iss;
    mto[k]  = fire;
    if (iss) mmeta[k] = mq[k].pop_front();
    else if (mst[k] == 1 && c > 0) void'(mq[k].pop_front());
    if (valid && mst[k] == 0 && c < 4) mq[k].push_back(req);
    if (mst[k] == 0) begin
      if (flush) mst[k] = 1;
    end else if (c == 0 && o == 0 && !flush) mst[k] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready", k, 64'(ready_o[k]), 64'(!rst && mst[k] == 0 && mq[k].size() < 4));
      chk("tlp_rd", k, 64'(rd_o[k]), 64'(mrd[k]));
      chk("meta", k, 64'({tag_o[k], len_o[k], id_o[k], la_o[k], at_o[k], tc_o[k]}), 64'(mmeta[k]));
      chk("timeout", k, 64'(tmo_o[k]), 64'(mto[k]));
      chk("outstanding", k, 64'(out_o[k]), 64'(mout[k]));
      chk("fifo_count", k, 64'(cnt_o[k]), 64'(mq[k].size()));
      chk("state", k, 64'(st_o[k]), 64'(mst[k]));
    end
  endtask

  task automatic set_req(input int tag);
    valid     = 1'b1;
    req.tag   = 10'(tag);
    req.len   = 2'($urandom_range(1, 2));
    req.id    = 16'($urandom);
    req.laddr = 7'($urandom);
    req.attr  = 3'($urandom);
    req.tc    = 3'($urandom);
  endtask

  task automatic do_reset();
    valid = 1'b0; cpl = 1'b0; flush = 1'b0; rst = 1'b1;
    tick();
    chk("ready_in_reset", 0, 64'(ready_o[0]), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_release", 0, 64'(ready_o[0]), 64'd1);
    chk("ready_after_release", 1, 64'(ready_o[1]), 64'd1);
  endtask

  initial begin
    int n, hold;

    do_reset();
    chk("reset_count", 0, 64'(cnt_o[0]), 64'd0);
    chk("reset_outstanding", 0, 64'(out_o[0]), 64'd0);
    chk("reset_state", 0, 64'(st_o[0]), 64'd0);
    chk("reset_meta", 0, 64'(tag_o[0]), 64'd0);

    // Allowance 1: second read waits for the completion of the first.
    set_req(5); tick();
    set_req(6); tick();
    chk("r19_pulse5", 0, 64'(rd_o[0]), 64'd1);
    chk("r19_tag5", 0, 64'(tag_o[0]), 64'd5);
    valid = 1'b0; tick();
    chk("r19_nopulse", 0, 64'(rd_o[0]), 64'd0);
    chk("r19_hold_tag", 0, 64'(tag_o[0]), 64'd5);
    cpl = 1'b1; tick();
    cpl = 1'b0;
    chk("r19_wait", 0, 64'(rd_o[0]), 64'd0);
    tick();
    chk("r19_pulse6", 0, 64'(rd_o[0]), 64'd1);
    chk("r19_tag6", 0, 64'(tag_o[0]), 64'd6);

    // Fill: 1 issued, 4 queued, then a completion frees the next issue.
    do_reset();
    for (int t = 1; t <= 5; t++) begin set_req(t); tick(); end
    valid = 1'b0;
    chk("r20_count", 0, 64'(cnt_o[0]), 64'd4);
    chk("r20_ready", 0, 64'(ready_o[0]), 64'd0);
    chk("r20_out", 0, 64'(out_o[0]), 64'd1);
    cpl = 1'b1; tick();
    cpl = 1'b0; tick();
    chk("r20_issue", 0, 64'(rd_o[0]), 64'd1);
    chk("r20_tag", 0, 64'(tag_o[0]), 64'd2);
    chk("r20_ready_back", 0, 64'(ready_o[0]), 64'd1);

    // Allowance 2: issue and completion on the same edge keep outstanding at 1.
    do_reset();
    set_req(11); tick();
    set_req(12); tick();
    valid = 1'b0; cpl = 1'b1; tick();
    cpl = 1'b0;
    chk("r21_issue", 1, 64'(rd_o[1]), 64'd1);
    chk("r21_tag", 1, 64'(tag_o[1]), 64'd12);
    chk("r21_out", 1, 64'(out_o[1]), 64'd1);

    // Timeout 16 cycles after issue, then the queued read goes out.
    do_reset();
    set_req(9); tick();
    set_req(10); tick();
    valid = 1'b0;
    chk("r22_issue", 0, 64'(rd_o[0]), 64'd1);
    n = 0;
    while (tmo_o[0] !== 1'b1 && n < 40) begin tick(); n++; end
    chk("r22_latency", 0, 64'(n), 64'd16);
    chk("r22_out", 0, 64'(out_o[0]), 64'd0);
    tick();
    chk("r22_next", 0, 64'(rd_o[0]), 64'd1);
    chk("r22_next_tag", 0, 64'(tag_o[0]), 64'd10);

    // Flush: 3 queued and 1 outstanding.
    do_reset();
    for (int t = 1; t <= 4; t++) begin set_req(t); tick(); end
    valid = 1'b0;
    chk("r23_pre_count", 0, 64'(cnt_o[0]), 64'd3);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("r23_state", 0, 64'(st_o[0]), 64'd1);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("r23_no_issue", 0, 64'(rd_o[0]), 64'd0);
    end
    chk("r23_count", 0, 64'(cnt_o[0]), 64'd0);
    cpl = 1'b1; tick();
    cpl = 1'b0; tick();
    chk("r23_run", 0, 64'(st_o[0]), 64'd0);

    // Reset mid-operation drops everything silently.
    do_reset();
    for (int t = 1; t <= 3; t++) begin set_req(t); tick(); end
    valid = 1'b0;
    chk("r24_pre_out", 0, 64'(out_o[0]), 64'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("r24_count", 0, 64'(cnt_o[0]), 64'd0);
    chk("r24_out", 0, 64'(out_o[0]), 64'd0);
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("r24_quiet_rd", 0, 64'(rd_o[0]), 64'd0);
      chk("r24_quiet_to", 0, 64'(tmo_o[0]), 64'd0);
    end

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0) set_req(int'($urandom_range(0, 1023)));
      else valid = 1'b0;
      cpl = ($urandom_range(0, 5) == 0);
      if (hold > 0) begin flush = 1'b1; hold--; end
      else begin
        flush = 1'b0;
        if ($urandom_range(0, 99) == 0) hold = int'($urandom_range(1, 5));
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
